// File: rtl/eval_result_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : eval_result_accumulator
// Description : Buffers evaluator results in a small FIFO and sums each group
//               of N_TERMS IEEE-754 singles through a multi-cycle float adder.
//               Also contains Task6_Addr_top, the enable/done float adder.
// Revision    : 1.0 - initial release
// ============================================================================
module eval_result_accumulator #(
  parameter int N_TERMS    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [31:0] sum,
  output logic        sum_valid,
  output logic        busy,
  output logic        drop
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ADD    = 3'd2,
    S_SETTLE = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic          drain_cnt;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   operand;
  logic [31:0]   acc;
  logic [7:0]    term_cnt;
  logic          add_enable;
  logic [31:0]   add_result;
  logic          add_done;
  logic          push, pop;

  // Ready comes from the registered count only, so a same-cycle pop never frees space.
  assign in_ready   = (count != CW'(FIFO_DEPTH));
  assign push       = in_valid & in_ready & ~clear;
  assign pop        = (state == S_LOAD) & (count != '0) & ~clear;
  assign drop       = in_valid & ~in_ready & ~clear;
  assign add_enable = (state == S_ADD);
  assign busy       = (count != '0) | (state != S_IDLE) | (term_cnt != 8'd0);

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // State register plus the two-cycle drain timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (!clear && state == S_DRAIN) ? 1'b1 : 1'b0;
    end
  end

  // Next-state logic; clear overrides everything and forces a drain.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = S_DRAIN;
    end else begin
      case (state)
        S_IDLE:   if (count != '0) state_nxt = S_LOAD;
        S_LOAD:   state_nxt = S_ADD;
        S_ADD:    if (add_done) state_nxt = S_SETTLE;
        S_SETTLE: state_nxt = (count != '0) ? S_LOAD : S_IDLE;
        S_DRAIN:  if (drain_cnt) state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Operand capture, accumulation and group completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      operand   <= '0;
      acc       <= '0;
      term_cnt  <= '0;
      sum       <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      if (clear) begin
        acc      <= '0;
        term_cnt <= '0;
      end else begin
        if (pop) operand <= mem[rd_ptr];
        if (state == S_ADD && add_done) begin
          acc      <= add_result;
          term_cnt <= term_cnt + 8'd1;
          // Publish the group here so sum_valid lines up with the SETTLE cycle.
          if (term_cnt + 8'd1 == 8'(N_TERMS)) begin
            sum       <= add_result;
            sum_valid <= 1'b1;
          end
        end
        if (state == S_SETTLE && term_cnt == 8'(N_TERMS)) begin
          acc      <= '0;
          term_cnt <= '0;
        end
      end
    end
  end

  Task6_Addr_top #(.LATENCY(10)) u_adder (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (add_enable),
    .dataa   (acc),
    .datab   (operand),
    .result  (add_result),
    .done    (add_done)
  );

endmodule

// ============================================================================
// Module      : Task6_Addr_top
// Description : Multi-cycle IEEE-754 single adder, round-to-nearest-even.
//               Starts when enable is seen high while armed, pulses done after
//               LATENCY cycles, then needs enable low for a cycle to re-arm.
// Revision    : 1.0 - initial release
// ============================================================================
module Task6_Addr_top #(
  parameter int LATENCY = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done
);

  logic [7:0]  cnt;
  logic        armed;
  logic [31:0] add_r;
  logic        sx, sy;
  logic [9:0]  ex, ey, e, diff;
  logic [23:0] mx_m, my_m;
  logic [26:0] mx, my, s;
  logic [53:0] tmp;
  logic [27:0] raw;
  logic [5:0]  sh;
  logic [24:0] m;
  logic        up;
  logic        nan_a, nan_b, inf_a, inf_b;

  // Combinational float add: align, add/subtract, normalise, round, special cases.
  always_comb begin
    sx = dataa[31]; sy = datab[31];
    ex = '0; ey = '0; mx_m = '0; my_m = '0;
    diff = '0; sh = '0; tmp = '0; raw = '0; s = '0; m = '0; up = 1'b0;
    add_r = '0;
    if (dataa[30:0] >= datab[30:0]) begin
      sx   = dataa[31];
      ex   = {2'b00, (dataa[30:23] == 8'd0) ? 8'd1 : dataa[30:23]};
      mx_m = {|dataa[30:23], dataa[22:0]};
      sy   = datab[31];
      ey   = {2'b00, (datab[30:23] == 8'd0) ? 8'd1 : datab[30:23]};
      my_m = {|datab[30:23], datab[22:0]};
    end else begin
      sx   = datab[31];
      ex   = {2'b00, (datab[30:23] == 8'd0) ? 8'd1 : datab[30:23]};
      mx_m = {|datab[30:23], datab[22:0]};
      sy   = dataa[31];
      ey   = {2'b00, (dataa[30:23] == 8'd0) ? 8'd1 : dataa[30:23]};
      my_m = {|dataa[30:23], dataa[22:0]};
    end
    diff = ex - ey;
    sh   = (diff > 10'd31) ? 6'd31 : diff[5:0];
    mx   = {mx_m, 3'b000};
    tmp  = {my_m, 3'b000, 27'd0} >> sh;
    my   = tmp[53:27] | {26'd0, |tmp[26:0]};
    e    = ex;
    if (sx == sy) begin
      raw = {1'b0, mx} + {1'b0, my};
      if (raw[27]) begin
        s = raw[27:1] | {26'd0, raw[0]};
        e = e + 10'd1;
      end else begin
        s = raw[26:0];
      end
    end else begin
      raw = {1'b0, mx} - {1'b0, my};
      s   = raw[26:0];
      for (int i = 0; i < 27; i++) begin
        if (!s[26] && e > 10'd1) begin
          s = s << 1;
          e = e - 10'd1;
        end
      end
    end
    up = s[2] & (s[1] | s[0] | s[3]);
    m  = {1'b0, s[26:3]} + {24'd0, up};
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'd1;
    end
    if (s == '0)
      add_r = {dataa[31] & datab[31], 31'd0};
    else if (e >= 10'd255)
      add_r = {sx, 8'hFF, 23'd0};
    else
      add_r = {sx, m[23] ? e[7:0] : 8'h00, m[22:0]};

    nan_a = (dataa[30:23] == 8'hFF) && (dataa[22:0] != '0);
    nan_b = (datab[30:23] == 8'hFF) && (datab[22:0] != '0);
    inf_a = (dataa[30:23] == 8'hFF) && (dataa[22:0] == '0);
    inf_b = (datab[30:23] == 8'hFF) && (datab[22:0] == '0);
    if (nan_a || nan_b || (inf_a && inf_b && (dataa[31] != datab[31])))
      add_r = 32'h7FC00000;
    else if (inf_a)
      add_r = dataa;
    else if (inf_b)
      add_r = datab;
  end

  // Latency counter and enable/done handshake; dropping enable re-arms.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      armed  <= 1'b1;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (!enable) begin
        armed <= 1'b1;
        cnt   <= '0;
      end else if (armed) begin
        if (cnt == 8'(LATENCY - 1)) begin
          done   <= 1'b1;
          result <= add_r;
          armed  <= 1'b0;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eval_result_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_eval_result_accumulator
// Description : Scoreboard bench for eval_result_accumulator: stimulus queues
//               expected group sums, a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eval_result_accumulator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic [31:0] sum;
  logic        sum_valid;
  logic        busy;
  logic        drop;

  int          tests = 0;
  int          fails = 0;
  int          drop_cnt = 0;
  logic        prev_sv = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  eval_result_accumulator #(.N_TERMS(2), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .sum       (sum),
    .sum_valid (sum_valid),
    .busy      (busy),
    .drop      (drop)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every sum_valid pulse must match the oldest expected group sum.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_sv = 1'b0;
    end else begin
      if (drop) drop_cnt++;
      if (sum_valid) begin
        check("sum_valid_gap", {31'd0, prev_sv}, 32'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_sum: got %h, expected no pulse", sum);
        end else begin
          check("group_sum", sum, exp_q.pop_front());
        end
      end
      prev_sv = sum_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      step();
      n++;
    end
    check(name, {31'd0, n >= 400}, 32'd0);
  endtask

  task automatic wait_queue(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      step();
      n++;
    end
    check(name, {31'd0, n >= 400}, 32'd0);
  endtask

  task automatic wait_enable(input string name);
    int n = 0;
    while (!dut.add_enable && n < 50) begin
      step();
      n++;
    end
    check(name, {31'd0, n >= 50}, 32'd0);
  endtask

  logic [31:0] burst_words [6] = '{32'h3F800000, 32'h40000000, 32'h40800000,
                                   32'h41000000, 32'h41800000, 32'h42000000};

  initial begin
    int accepted;
    int n;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_sum", sum, 32'h00000000);
    check("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_drop", {31'd0, drop}, 32'd0);
    reset_n = 1'b1;
    step();

    // Single group 1.0 + 2.0; busy drops one cycle after SETTLE
    push(32'h3F800000);
    push(32'h40000000);
    exp_q.push_back(32'h40400000);
    n = 0;
    while (!sum_valid && n < 100) begin
      step();
      n++;
    end
    check("t1_sum_valid_seen", {31'd0, sum_valid}, 32'd1);
    step();
    check("t1_busy_after_settle", {31'd0, busy}, 32'd0);
    wait_idle("t1_timeout");

    // Two groups: accumulator restarts between them
    push(32'h3F800000);
    push(32'h40000000);
    push(32'h3F000000);
    push(32'h3E800000);
    exp_q.push_back(32'h40400000);
    exp_q.push_back(32'h3F400000);
    wait_idle("t2_timeout");

    // Burst of six: five accepted, one dropped
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = burst_words[i];
      if (in_ready) accepted++;
      step();
    end
    in_valid = 1'b0;
    check("burst_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("burst_accepted", accepted, 32'd5);
    exp_q.push_back(32'h40400000);
    exp_q.push_back(32'h41400000);
    wait_queue("t3_timeout");
    check("burst_drop_count", drop_cnt, 32'd1);
    push(32'h3F000000);
    exp_q.push_back(32'h41840000);
    wait_idle("t3b_timeout");

    // clear during ADD: enable falls, nothing completes, sum held
    push(32'h3F800000);
    wait_enable("t4_enable_timeout");
    repeat (3) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_enable_low", {31'd0, dut.add_enable}, 32'd0);
    check("clr_sum_held", sum, 32'h41840000);
    repeat (20) step();
    check("clr_busy_idle", {31'd0, busy}, 32'd0);
    check("clr_sum_still_held", sum, 32'h41840000);
    push(32'h3F800000);
    push(32'h40000000);
    exp_q.push_back(32'h40400000);
    wait_idle("t4_timeout");

    // Asynchronous reset in the middle of an addition
    push(32'h3F800000);
    wait_enable("t5_enable_timeout");
    repeat (2) step();
    #2 reset_n = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_sum", sum, 32'h00000000);
    check("arst_sum_valid", {31'd0, sum_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_enable", {31'd0, dut.add_enable}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    check("arst_fifo_empty", {31'd0, busy}, 32'd0);
    push(32'h3F800000);
    push(32'h40000000);
    exp_q.push_back(32'h40400000);
    wait_idle("t5_timeout");

    // Opposite signs cancel to +0.0
    push(32'hC0000000);
    push(32'h40000000);
    exp_q.push_back(32'h00000000);
    wait_idle("t6_timeout");

    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
